// File: rtl/guess_game_core.sv
// Game-control core for the number-guessing game: digit entry, guess/hint compare,
// per-round countdown and round/guess bookkeeping in one FSM over N BCD digits.
module guess_game_core #(
   parameter int NUM_DIGITS    = 3,
   parameter int MAX_ROUNDS    = 3,
   parameter int MAX_GUESSES   = 5,
   parameter int TICKS_PER_SEC = 50000000,
   parameter int SEC_PER_DIGIT = 20
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [1:0]              difficulty,
   input  logic [NUM_DIGITS-1:0]   digit_inc,
   input  logic                    confirm,
   input  logic [4*NUM_DIGITS-1:0] target,
   input  logic                    target_valid,
   output logic                    target_req,
   output logic [4*NUM_DIGITS-1:0] entry,
   output logic [2:0]              active_digits,
   output logic [1:0]              hint,
   output logic [3:0]              guesses_left,
   output logic [2:0]              round,
   output logic [7:0]              time_left,
   output logic [1:0]              status
);

   localparam int DW = 4 * NUM_DIGITS;
   localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PW-1:0] TMAX = PW'(TICKS_PER_SEC - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_PLAY, S_CHECK, S_RDONE, S_WIN, S_LOSE
   } state_t;

   state_t          state_q, state_d;
   logic [2:0]      act_q, act_d, round_q, round_d;
   logic [3:0]      guesses_q, guesses_d;
   logic [7:0]      time_q, time_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic [1:0]      hint_q, hint_d;
   logic [DW-1:0]   entry_q, entry_d, guess_q, guess_d, target_q, target_d;
   logic            treq_q, treq_d;

   logic [DW-1:0]   act_mask, entry_inc;
   logic [2:0]      act_start;
   logic            tick;

   function automatic logic [3:0] bcd_inc(input logic [3:0] d);
      return (d >= 4'd9) ? 4'd0 : d + 4'd1;
   endfunction

   // Per-digit increment and active-digit mask; inactive digits never move.
   always_comb begin
      act_mask  = '0;
      entry_inc = entry_q;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (3'(i) < act_q) begin
            act_mask[4*i +: 4] = 4'hF;
            if (digit_inc[i]) entry_inc[4*i +: 4] = bcd_inc(entry_q[4*i +: 4]);
         end
      end
   end

   always_comb begin
      act_start = {1'b0, difficulty};
      if (difficulty == 2'd0)                   act_start = 3'd1;
      else if ({1'b0, difficulty} > 3'(NUM_DIGITS)) act_start = 3'(NUM_DIGITS);
   end

   assign tick = (presc_q == TMAX);

   always_comb begin
      state_d   = state_q;
      act_d     = act_q;
      round_d   = round_q;
      guesses_d = guesses_q;
      time_d    = time_q;
      presc_d   = presc_q;
      hint_d    = hint_q;
      entry_d   = entry_q;
      guess_d   = guess_q;
      target_d  = target_q;
      treq_d    = 1'b0;
      case (state_q)
         S_IDLE, S_WIN, S_LOSE: begin
            if (start) begin
               act_d   = act_start;
               round_d = 3'd1;
               hint_d  = 2'b00;
               treq_d  = 1'b1;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (target_valid) begin
               target_d  = target & act_mask;
               entry_d   = '0;
               guesses_d = 4'(MAX_GUESSES);
               time_d    = 8'(SEC_PER_DIGIT * int'(act_q));
               presc_d   = '0;
               hint_d    = 2'b00;
               state_d   = S_PLAY;
            end
         end
         S_PLAY: begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) time_d = (time_q == 8'd0) ? 8'd0 : time_q - 8'd1;
            // Expiry takes priority over a confirm landing on the same edge.
            if (tick && time_q <= 8'd1) begin
               hint_d  = 2'b00;
               state_d = S_LOSE;
            end else if (confirm) begin
               guess_d = entry_q;
               state_d = S_CHECK;
            end else begin
               entry_d = entry_inc;
            end
         end
         S_CHECK: begin
            if ((guess_q & act_mask) == target_q) begin
               hint_d  = 2'b11;
               state_d = S_RDONE;
            end else begin
               hint_d    = ((guess_q & act_mask) < target_q) ? 2'b01 : 2'b10;
               guesses_d = (guesses_q == 4'd0) ? 4'd0 : guesses_q - 4'd1;
               state_d   = (guesses_q <= 4'd1) ? S_LOSE : S_PLAY;
            end
         end
         S_RDONE: begin
            if (round_q >= 3'(MAX_ROUNDS)) begin
               state_d = S_WIN;
            end else begin
               round_d = round_q + 3'd1;
               treq_d  = 1'b1;
               state_d = S_LOAD;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         act_q     <= '0;
         round_q   <= '0;
         guesses_q <= '0;
         time_q    <= '0;
         presc_q   <= '0;
         hint_q    <= '0;
         entry_q   <= '0;
         guess_q   <= '0;
         target_q  <= '0;
         treq_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         act_q     <= act_d;
         round_q   <= round_d;
         guesses_q <= guesses_d;
         time_q    <= time_d;
         presc_q   <= presc_d;
         hint_q    <= hint_d;
         entry_q   <= entry_d;
         guess_q   <= guess_d;
         target_q  <= target_d;
         treq_q    <= treq_d;
      end
   end

   always_comb begin
      case (state_q)
         S_IDLE:  status = 2'b00;
         S_WIN:   status = 2'b10;
         S_LOSE:  status = 2'b11;
         default: status = 2'b01;
      endcase
   end

   assign target_req    = treq_q;
   assign entry         = entry_q;
   assign active_digits = act_q;
   assign hint          = hint_q;
   assign guesses_left  = guesses_q;
   assign round         = round_q;
   assign time_left     = time_q;

endmodule

// File: tb/tb_guess_game_core.sv
// Directed bench for guess_game_core with a 4-cycle second and 2 s per digit.
module tb_guess_game_core;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  difficulty = 2'd0;
   logic [2:0]  digit_inc = 3'b000;
   logic        confirm = 1'b0;
   logic [11:0] target = 12'h000;
   logic        target_valid = 1'b0;
   logic        target_req;
   logic [11:0] entry;
   logic [2:0]  active_digits;
   logic [1:0]  hnt;
   logic [3:0]  guesses_left;
   logic [2:0]  round;
   logic [7:0]  time_left;
   logic [1:0]  status;

   int ncmp = 0;
   int nerr = 0;

   guess_game_core #(
      .NUM_DIGITS(3), .MAX_ROUNDS(2), .MAX_GUESSES(3),
      .TICKS_PER_SEC(4), .SEC_PER_DIGIT(2)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .difficulty(difficulty),
      .digit_inc(digit_inc), .confirm(confirm), .target(target),
      .target_valid(target_valid), .target_req(target_req), .entry(entry),
      .active_digits(active_digits), .hint(hnt), .guesses_left(guesses_left),
      .round(round), .time_left(time_left), .status(status)
   );

   always #5 clk = ~clk;

   // Advance n edges; inputs change and outputs are sampled 1 ns after each edge.
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
   endtask

   task automatic do_start(input logic [1:0] d);
      start = 1'b1; difficulty = d;
      cyc(1);
      start = 1'b0;
   endtask

   task automatic give_target(input logic [11:0] t);
      target = t; target_valid = 1'b1;
      cyc(1);
      target_valid = 1'b0;
   endtask

   task automatic inc(input int b, input int n);
      repeat (n) begin
         digit_inc = 3'b000;
         digit_inc[b] = 1'b1;
         cyc(1);
      end
      digit_inc = 3'b000;
   endtask

   task automatic do_confirm();
      confirm = 1'b1;
      cyc(1);
      confirm = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      ncmp++; if (status !== 2'b00) begin nerr++; $display("FAIL rst_status got=%0h exp=0", status); end
      ncmp++; if (round !== 3'd0) begin nerr++; $display("FAIL rst_round got=%0d exp=0", round); end
      ncmp++; if ({target_req, entry, active_digits, hnt, guesses_left, time_left} !== '0)
         begin nerr++; $display("FAIL rst_outputs got=%h exp=0", {target_req, entry, active_digits, hnt, guesses_left, time_left}); end
   endtask

   task automatic test_start();
      do_start(2'd3);
      ncmp++; if (target_req !== 1'b1) begin nerr++; $display("FAIL start_treq got=%b exp=1", target_req); end
      ncmp++; if (active_digits !== 3'd3) begin nerr++; $display("FAIL start_act got=%0d exp=3", active_digits); end
      ncmp++; if (round !== 3'd1) begin nerr++; $display("FAIL start_round got=%0d exp=1", round); end
      give_target(12'h482);
      ncmp++; if (target_req !== 1'b0) begin nerr++; $display("FAIL load_treq got=%b exp=0", target_req); end
      ncmp++; if (status !== 2'b01) begin nerr++; $display("FAIL load_status got=%0h exp=1", status); end
      ncmp++; if (time_left !== 8'd6) begin nerr++; $display("FAIL load_time got=%0d exp=6", time_left); end
      ncmp++; if (guesses_left !== 4'd3) begin nerr++; $display("FAIL load_guesses got=%0d exp=3", guesses_left); end
   endtask

   task automatic test_hints();
      do_start(2'd1);
      ncmp++; if (target_req !== 1'b0 || round !== 3'd1 || active_digits !== 3'd3)
         begin nerr++; $display("FAIL play_start_ignored got=%b/%0d/%0d exp=0/1/3", target_req, round, active_digits); end
      inc(2, 3);
      ncmp++; if (entry !== 12'h300) begin nerr++; $display("FAIL entry_300 got=%h exp=300", entry); end
      do_confirm();
      ncmp++; if (hnt !== 2'b00) begin nerr++; $display("FAIL hint_latency got=%b exp=00", hnt); end
      cyc(1);
      ncmp++; if (hnt !== 2'b01) begin nerr++; $display("FAIL hint_low got=%b exp=01", hnt); end
      ncmp++; if (guesses_left !== 4'd2) begin nerr++; $display("FAIL guesses_2 got=%0d exp=2", guesses_left); end
      ncmp++; if (entry !== 12'h300) begin nerr++; $display("FAIL entry_kept got=%h exp=300", entry); end
      inc(2, 2);
      do_confirm(); cyc(1);
      ncmp++; if (hnt !== 2'b10) begin nerr++; $display("FAIL hint_high got=%b exp=10", hnt); end
      ncmp++; if (guesses_left !== 4'd1) begin nerr++; $display("FAIL guesses_1 got=%0d exp=1", guesses_left); end
   endtask

   task automatic test_lose_guesses();
      do_confirm(); cyc(1);
      ncmp++; if (guesses_left !== 4'd0) begin nerr++; $display("FAIL guesses_0 got=%0d exp=0", guesses_left); end
      ncmp++; if (status !== 2'b11) begin nerr++; $display("FAIL lose_status got=%0h exp=3", status); end
      digit_inc = 3'b111; confirm = 1'b1;
      cyc(3);
      digit_inc = 3'b000; confirm = 1'b0;
      ncmp++; if (entry !== 12'h500 || status !== 2'b11 || guesses_left !== 4'd0)
         begin nerr++; $display("FAIL lose_hold got=%h/%0h/%0d exp=500/3/0", entry, status, guesses_left); end
   endtask

   task automatic test_win();
      do_reset();
      do_start(2'd3);
      give_target(12'h482);
      inc(2, 4); inc(1, 8); inc(0, 2);
      do_confirm(); cyc(1);
      ncmp++; if (hnt !== 2'b11) begin nerr++; $display("FAIL win_hint1 got=%b exp=11", hnt); end
      ncmp++; if (guesses_left !== 4'd3) begin nerr++; $display("FAIL win_guesses got=%0d exp=3", guesses_left); end
      cyc(1);
      ncmp++; if (round !== 3'd2 || target_req !== 1'b1 || status !== 2'b01)
         begin nerr++; $display("FAIL round2 got=%0d/%b/%0h exp=2/1/1", round, target_req, status); end
      give_target(12'h007);
      ncmp++; if (entry !== 12'h000 || time_left !== 8'd6) begin nerr++; $display("FAIL round2_load got=%h/%0d exp=000/6", entry, time_left); end
      inc(0, 7);
      do_confirm(); cyc(1);
      ncmp++; if (hnt !== 2'b11) begin nerr++; $display("FAIL win_hint2 got=%b exp=11", hnt); end
      cyc(1);
      ncmp++; if (status !== 2'b10 || round !== 3'd2 || target_req !== 1'b0)
         begin nerr++; $display("FAIL win_status got=%0h/%0d/%b exp=2/2/0", status, round, target_req); end
   endtask

   task automatic test_timeout();
      do_reset();
      do_start(2'd3);
      give_target(12'h482);
      for (int s = 1; s <= 5; s++) begin
         cyc(4);
         ncmp++; if (time_left !== 8'(6 - s)) begin nerr++; $display("FAIL time_step%0d got=%0d exp=%0d", s, time_left, 6 - s); end
      end
      cyc(3);
      ncmp++; if (status !== 2'b01 || time_left !== 8'd1) begin nerr++; $display("FAIL pre_timeout got=%0h/%0d exp=1/1", status, time_left); end
      cyc(1);
      ncmp++; if (status !== 2'b11 || time_left !== 8'd0 || hnt !== 2'b00)
         begin nerr++; $display("FAIL timeout got=%0h/%0d/%b exp=3/0/00", status, time_left, hnt); end
   endtask

   task automatic test_tick_confirm();
      do_reset();
      do_start(2'd3);
      give_target(12'h482);
      cyc(23);
      do_confirm();
      ncmp++; if (status !== 2'b11 || guesses_left !== 4'd3 || hnt !== 2'b00)
         begin nerr++; $display("FAIL tick_confirm got=%0h/%0d/%b exp=3/3/00", status, guesses_left, hnt); end
      cyc(1);
      ncmp++; if (status !== 2'b11 || guesses_left !== 4'd3) begin nerr++; $display("FAIL tick_confirm_hold got=%0h/%0d exp=3/3", status, guesses_left); end
   endtask

   task automatic test_clamp();
      do_reset();
      do_start(2'd0);
      ncmp++; if (active_digits !== 3'd1) begin nerr++; $display("FAIL clamp_act got=%0d exp=1", active_digits); end
      give_target(12'h482);
      ncmp++; if (time_left !== 8'd2) begin nerr++; $display("FAIL clamp_time got=%0d exp=2", time_left); end
      digit_inc = 3'b110; cyc(1); digit_inc = 3'b000;
      ncmp++; if (entry !== 12'h000) begin nerr++; $display("FAIL inactive_inc got=%h exp=000", entry); end
      // Only digit 0 of the target survives, so 2 is the right answer.
      inc(0, 2);
      do_confirm(); cyc(1);
      ncmp++; if (hnt !== 2'b11) begin nerr++; $display("FAIL masked_target got=%b exp=11", hnt); end
   endtask

   task automatic test_wrap();
      do_reset();
      do_start(2'd3);
      give_target(12'h000);
      inc(0, 9);
      ncmp++; if (entry !== 12'h009) begin nerr++; $display("FAIL wrap_9 got=%h exp=009", entry); end
      inc(0, 1);
      ncmp++; if (entry !== 12'h000) begin nerr++; $display("FAIL wrap_0 got=%h exp=000", entry); end
      inc(1, 11);
      ncmp++; if (entry !== 12'h010) begin nerr++; $display("FAIL wrap_11 got=%h exp=010", entry); end
      digit_inc = 3'b111; cyc(1); digit_inc = 3'b000;
      ncmp++; if (entry !== 12'h121) begin nerr++; $display("FAIL multi_inc got=%h exp=121", entry); end
      do_confirm(); cyc(1);
      ncmp++; if (hnt !== 2'b10 || guesses_left !== 4'd2) begin nerr++; $display("FAIL wrap_hint got=%b/%0d exp=10/2", hnt, guesses_left); end
   endtask

   task automatic test_mid_reset();
      do_reset();
      do_start(2'd3);
      give_target(12'h482);
      inc(2, 1);
      do_confirm();
      rst = 1'b1; cyc(1); rst = 1'b0;
      ncmp++; if (status !== 2'b00 || round !== 3'd0 || hnt !== 2'b00)
         begin nerr++; $display("FAIL midrst got=%0h/%0d/%b exp=0/0/00", status, round, hnt); end
      ncmp++; if ({entry, guesses_left, time_left, active_digits} !== '0)
         begin nerr++; $display("FAIL midrst_clear got=%h exp=0", {entry, guesses_left, time_left, active_digits}); end
      do_start(2'd2);
      ncmp++; if (target_req !== 1'b1 || active_digits !== 3'd2) begin nerr++; $display("FAIL restart got=%b/%0d exp=1/2", target_req, active_digits); end
      give_target(12'h482);
      ncmp++; if (time_left !== 8'd4) begin nerr++; $display("FAIL restart_time got=%0d exp=4", time_left); end
      inc(1, 8); inc(0, 2);
      do_confirm(); cyc(1);
      ncmp++; if (hnt !== 2'b11) begin nerr++; $display("FAIL restart_hint got=%b exp=11", hnt); end
   endtask

   initial begin
      test_reset();
      test_start();
      test_hints();
      test_lose_guesses();
      test_win();
      test_timeout();
      test_tick_confirm();
      test_clamp();
      test_wrap();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule

// File: doc/guess_game_core.md
Name: guess_game_core

Overview:
Parametrised game-control core for the number-guessing game. It merges digit entry, the guess/hint comparison, the per-round countdown timer, and the round and guess bookkeeping into one FSM, generalised to N BCD digits. It requests a new target from the target generator at every round start. It sits between the input synchronisers and the seven-segment/LED display block.

Parameters:
NUM_DIGITS, 3, maximum BCD digits per guess (1..4)
MAX_ROUNDS, 3, rounds to clear for a win (1..7)
MAX_GUESSES, 5, guesses allowed per round (1..15)
TICKS_PER_SEC, 50000000, clk cycles per timer second
SEC_PER_DIGIT, 20, round time budget per active digit; SEC_PER_DIGIT*NUM_DIGITS <= 255

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a game from IDLE, WIN or LOSE
difficulty  in  2  requested active digit count, sampled on start
digit_inc  in  NUM_DIGITS  one-cycle pulses; bit i increments entry digit i (bit 0 = least significant)
confirm  in  1  one-cycle pulse; submits the current entry
target  in  4*NUM_DIGITS  BCD target, digit 0 in bits [3:0]
target_valid  in  1  target is stable; sampled in LOAD
target_req  out  1  one-cycle pulse requesting a new target
entry  out  4*NUM_DIGITS  current BCD entry, for display
active_digits  out  3  latched active digit count (1..NUM_DIGITS)
hint  out  2  00 none, 01 LOW (guess<target), 10 HIGH, 11 correct
guesses_left  out  4  guesses remaining this round
round  out  3  current round (1..MAX_ROUNDS), 0 in IDLE
time_left  out  8  seconds remaining this round
status  out  2  00 idle, 01 playing, 10 win, 11 lose

Behaviour:
- rst (sampled at the clk edge) -> state IDLE. All outputs 0; internal prescaler, guess register and latched target cleared. rst overrides every other input, including mid-round.
- active_digits: latched on start. difficulty 0 maps to 1; values > NUM_DIGITS are clamped to NUM_DIGITS.
- States: IDLE, LOAD, PLAY, CHECK, ROUND_DONE, WIN, LOSE.
- IDLE/WIN/LOSE + start:
  - round=1, hint=00, target_req=1 for one cycle, go to LOAD.
  - In WIN/LOSE, all other inputs are ignored and outputs hold their final values.
- LOAD: wait for target_valid. On the cycle it is high:
  - latch target, zeroing digits >= active_digits;
  - entry=0, guesses_left=MAX_GUESSES, time_left=SEC_PER_DIGIT*active_digits, prescaler=0, hint=00;
  - go to PLAY.
- PLAY digit entry:
  - digit_inc[i] with i < active_digits increments digit i modulo 10 (9->0).
  - Pulses on inactive bits are ignored; simultaneous pulses on several bits all apply.
- PLAY timer:
  - prescaler counts clk cycles; at TICKS_PER_SEC-1 it wraps and time_left decrements.
  - time_left reaching 0 -> hint=00, go to LOSE.
  - Timer runs only in PLAY; it is frozen in LOAD, CHECK and ROUND_DONE.
- PLAY confirm:
  - register entry into the guess register, go to CHECK.
  - Digit pulses in the same cycle are dropped.
  - If the final decrement to 0 and confirm land in the same cycle, the timeout wins: LOSE.
- CHECK (exactly 1 cycle), unsigned BCD magnitude compare of guess vs target over active digits:
  - equal -> hint=11, go to ROUND_DONE;
  - guess<target -> hint=01; guess>target -> hint=10; in both cases guesses_left -= 1, then go to LOSE if the result is 0, otherwise back to PLAY;
  - entry is kept as typed.
  - Hint is visible 2 cycles after the confirm pulse.
- ROUND_DONE (1 cycle):
  - round==MAX_ROUNDS -> WIN;
  - otherwise round += 1, target_req pulse, go to LOAD.
- status: 00 in IDLE; 01 in LOAD/PLAY/CHECK/ROUND_DONE; 10 in WIN; 11 in LOSE.
- start in any playing state is ignored.
- guesses_left never underflows; round never exceeds MAX_ROUNDS.

Test Plan:
- Parameters NUM_DIGITS=3, MAX_ROUNDS=2, MAX_GUESSES=3, TICKS_PER_SEC=4, SEC_PER_DIGIT=2 for all scenarios below.
- Reset/start: rst 2 cycles -> all outputs 0. start with difficulty=3 -> target_req pulse; target=0x482 with target_valid -> status=01, time_left=6, guesses_left=3, round=1.
- Hints: target 0x482; enter 0x300 (3 pulses on bit 2) and confirm -> hint=01, guesses_left=2 two cycles later. Enter 0x500 and confirm -> hint=10, guesses_left=1.
- Full win: correct guess in round 1 -> hint=11, then round=2 with a second target_req. Correct guess in round 2 -> status=10, round=2.
- Loss paths: three wrong guesses -> guesses_left=0, status=11. Separately, idle for 24 cycles -> time_left steps 6..0, status=11. Final tick coincident with confirm -> LOSE, guesses_left unchanged.
- Clamp and wrap: difficulty=0 -> active_digits=1, time_left=2; digit_inc=3'b110 has no effect. Ten pulses on bit 0 -> digit returns to 0. difficulty=3 with eleven bit-1 pulses -> entry=0x010.
- Mid-game rst: assert rst in CHECK -> next cycle status=00, round=0, hint=00. A following start runs normally.
